// File: rtl/switch_debouncer.sv
// Multi-channel switch debouncer: two-flop synchroniser, per-channel stability counter,
// registered clean level plus single-cycle rise/fall strobes.
module switch_debouncer #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic             CLK50MHZ,
  input  logic             RST,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Any cycle where the synchronised input matches the stable level restarts the count.
  always_comb begin
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = sync2_q[i];
          rise_d[i]   = sync2_q[i];
          fall_d[i]   = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= sw_in;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sw_out  = stable_q;
  assign sw_rise = rise_q;
  assign sw_fall = fall_q;

endmodule
